stream_packer: RTL
==================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, giving the input beat width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving beats per output word (legal 2..16).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_clk_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, DATA_SIZE bits: input beat, sourced from the skid buffer output.
REQ-006 The block SHALL have port data_valid_i, input, 1 bit: input beat valid.
REQ-007 The block SHALL have port data_ready_o, output, 1 bit: block accepts the input beat this cycle.
REQ-008 The block SHALL have port flush_i, input, 1 bit: level request to emit a partial word.
REQ-009 The block SHALL have port data_o, output, DATA_SIZE*RATIO bits: packed output word.
REQ-010 The block SHALL have port word_bytes_o, output, $clog2(RATIO+1) bits: number of valid beats in data_o (1..RATIO).
REQ-011 The block SHALL have port data_valid_o, output, 1 bit: output word valid.
REQ-012 The block SHALL have port data_ready_i, input, 1 bit: downstream accepts the output word.

Function
REQ-013 An input beat SHALL be accepted on a rising edge where data_valid_i && data_ready_o; an output word SHALL be transferred where data_valid_o && data_ready_i.
REQ-014 The k-th accepted beat of a word (k = 0..RATIO-1) SHALL occupy data_o bits [k*DATA_SIZE +: DATA_SIZE], i.e. little-endian packing.
REQ-015 The block SHALL hold an accumulator and a beat counter cnt (0..RATIO-1), plus a single registered output slot (data_o, word_bytes_o, data_valid_o).
REQ-016 slot_free SHALL be defined as !data_valid_o || data_ready_i.
REQ-017 data_ready_o SHALL be combinational: 0 when rst_clk_ni is low; else 0 only when !slot_free && (cnt == RATIO-1 || flush_i); otherwise 1.
REQ-018 A word SHALL complete on an accepted beat when cnt == RATIO-1 (word_bytes_o = RATIO) or flush_i = 1 (word_bytes_o = cnt+1).
REQ-019 A word SHALL complete without an input beat when flush_i = 1, cnt > 0 and slot_free; word_bytes_o SHALL equal cnt.
REQ-020 On completion the word SHALL load the output slot on the same edge, so data_valid_o is high in the cycle after the completing edge (latency 1), and cnt and the accumulator SHALL clear to 0.
REQ-021 Unused upper beats of a flushed word SHALL be driven to zero in data_o.
REQ-022 flush_i with cnt == 0 and no accepted beat SHALL be a no-op; flush_i while !slot_free SHALL be ignored that cycle (no state change from the flush).
REQ-023 A non-completing accepted beat SHALL increment cnt and SHALL be accepted regardless of output slot state.
REQ-024 If the slot transfers and no new word completes on the same edge, data_valid_o SHALL go low; if both occur, the slot SHALL reload with data_valid_o held high (back-to-back).
REQ-025 data_o and word_bytes_o SHALL be stable while data_valid_o && !data_ready_i.
REQ-026 Sustained throughput SHALL be one input beat per cycle with data_ready_i held high (no bubbles at word boundaries).

Reset
REQ-027 While rst_clk_ni is low: data_valid_o = 0, data_o = 0, word_bytes_o = 0, cnt = 0, accumulator = 0, data_ready_o = 0.
REQ-028 Reset asserted mid-word or with a pending output word SHALL discard all partial and pending data; first beat after release SHALL be packed at position 0.

Verification
REQ-029 Beats 0x11,0x22,0x33,0x44 on consecutive cycles, data_ready_i = 1 -> one cycle later data_o = 0x44332211, word_bytes_o = 4, data_valid_o high for 1 cycle.
REQ-030 Beats 0xA1,0xA2 then flush_i = 1 for 1 cycle, no beat -> data_o = 0x0000A2A1, word_bytes_o = 2; cnt back to 0.
REQ-031 Word 0x04030201 pending with data_ready_i = 0, next beats 0x05,0x06,0x07 accepted, 0x08 -> data_ready_o = 0 until data_ready_i = 1; then 0x08 accepted same cycle and data_o = 0x08070605 with data_valid_o staying high.
REQ-032 Beat 0x55 with flush_i = 1 on the same cycle at cnt = 0 -> data_o = 0x00000055, word_bytes_o = 1.
REQ-033 Reset pulse after beats 0x01,0x02 -> outputs at reset values; next beats 0x09,0x0A,0x0B,0x0C -> data_o = 0x0C0B0A09.
REQ-034 4096 random beats, random data_valid_i/data_ready_i/flush_i -> scoreboard reconstruction of output words (using word_bytes_o) equals input byte stream in order, no loss or duplication.

Source files
------------

// File: rtl/stream_packer.sv
// Packs RATIO narrow input beats little-endian into one wide output word,
// with level-sensitive flush of partial words and a single registered output slot.
module stream_packer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned RATIO     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_clk_ni,
  input  logic [DATA_SIZE-1:0]           data_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  input  logic                           flush_i,
  output logic [DATA_SIZE*RATIO-1:0]     data_o,
  output logic [$clog2(RATIO+1)-1:0]     word_bytes_o,
  output logic                           data_valid_o,
  input  logic                           data_ready_i
);

  localparam int unsigned WORD_W  = DATA_SIZE * RATIO;
  localparam int unsigned CNT_W   = $clog2(RATIO);
  localparam int unsigned BYTES_W = $clog2(RATIO + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WORD_W-1:0]  acc_q, acc_n;
  logic [WORD_W-1:0]  data_n;
  logic [BYTES_W-1:0] bytes_n;
  logic               valid_n;

  logic               slot_free_c;
  logic               last_beat_c;
  logic               accept_c;
  logic               complete_beat_c;
  logic               complete_flush_c;
  logic [WORD_W-1:0]  merged_c;

  // The slot can take a new word if it is empty or being drained this cycle.
  assign slot_free_c  = !data_valid_o || data_ready_i;
  assign last_beat_c  = (cnt_q == CNT_W'(RATIO - 1));

  // Only a beat that would complete a word must wait for the output slot.
  assign data_ready_o = rst_clk_ni && !(!slot_free_c && (last_beat_c || flush_i));

  assign accept_c         = data_valid_i && data_ready_o;
  assign complete_beat_c  = accept_c && (last_beat_c || flush_i);
  assign complete_flush_c = !accept_c && flush_i && (cnt_q != '0) && slot_free_c;

  // Accumulator with the current beat dropped into its slot.
  always_comb begin
    merged_c = acc_q;
    merged_c[32'(cnt_q) * DATA_SIZE +: DATA_SIZE] = data_i;
  end

  // Next-state for accumulator, beat counter and output slot.
  always_comb begin
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    data_n  = data_o;
    bytes_n = word_bytes_o;
    valid_n = data_valid_o;

    if (data_valid_o && data_ready_i) begin
      valid_n = 1'b0;
    end

    if (complete_beat_c) begin
      data_n  = merged_c;
      bytes_n = BYTES_W'(cnt_q) + BYTES_W'(1);
      valid_n = 1'b1;
      acc_n   = '0;
      cnt_n   = '0;
    end else if (complete_flush_c) begin
      data_n  = acc_q;
      bytes_n = BYTES_W'(cnt_q);
      valid_n = 1'b1;
      acc_n   = '0;
      cnt_n   = '0;
    end else if (accept_c) begin
      acc_n = merged_c;
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      data_o       <= '0;
      word_bytes_o <= '0;
      data_valid_o <= 1'b0;
    end else begin
      acc_q        <= acc_n;
      cnt_q        <= cnt_n;
      data_o       <= data_n;
      word_bytes_o <= bytes_n;
      data_valid_o <= valid_n;
    end
  end

endmodule
